// File: rtl/per_clk_rst_seq.sv
// Per-channel peripheral reset release and clock-enable sequencer
// with on-demand oscillator handshake and sticky timeout flags.
module per_clk_rst_seq #(
  parameter int CH_NUM = 4,
  parameter int CLK_ON_AFTER_PER_RST_RELEASE = 2,
  parameter int OSC_TIMEOUT = 64,
  parameter logic [CH_NUM-1:0] NEEDS_OSC = '0
) (
  input  logic              i_clk,
  input  logic              sys_rst,
  input  logic              testmode,
  input  logic [CH_NUM-1:0] sft_rst_req,
  input  logic [CH_NUM-1:0] run_req,
  input  logic              osc_rdy,
  input  logic [CH_NUM-1:0] err_clr,
  output logic [CH_NUM-1:0] per_rst_n,
  output logic [CH_NUM-1:0] clk_en,
  output logic              osc_req,
  output logic [CH_NUM-1:0] err
);

  localparam int DLY_W = (CLK_ON_AFTER_PER_RST_RELEASE > 0) ?
    $clog2(CLK_ON_AFTER_PER_RST_RELEASE + 1) : 1;
  localparam int TO_W = $clog2(OSC_TIMEOUT + 1);
  localparam logic [DLY_W-1:0] DLY_INIT =
    DLY_W'(CLK_ON_AFTER_PER_RST_RELEASE);
  localparam logic [TO_W-1:0] TO_INIT = TO_W'(OSC_TIMEOUT);

  typedef enum logic [2:0] {
    S_RESET,
    S_DELAY,
    S_IDLE,
    S_OREQ,
    S_RUN
  } state_e;

  state_e            state_q [CH_NUM];
  state_e            state_d [CH_NUM];
  logic [DLY_W-1:0]  dly_q   [CH_NUM];
  logic [DLY_W-1:0]  dly_d   [CH_NUM];
  logic [TO_W-1:0]   to_q    [CH_NUM];
  logic [TO_W-1:0]   to_d    [CH_NUM];
  logic [CH_NUM-1:0] rst_n_q, rst_n_d;
  logic [CH_NUM-1:0] en_q, en_d;
  logic [CH_NUM-1:0] err_q, err_d;
  logic [CH_NUM-1:0] req_d;
  logic [CH_NUM-1:0] err_set;
  logic              osc_req_q, osc_req_d;

  always_comb begin
    err_set = '0;
    rst_n_d = '0;
    en_d    = '0;
    req_d   = '0;
    err_d   = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      state_d[i] = state_q[i];
      dly_d[i]   = dly_q[i];
      to_d[i]    = to_q[i];
      // software reset beats every other transition, timeout included
      if (sft_rst_req[i]) begin
        state_d[i] = S_RESET;
        dly_d[i]   = '0;
        to_d[i]    = '0;
      end else begin
        unique case (state_q[i])
          S_RESET: begin
            if (CLK_ON_AFTER_PER_RST_RELEASE == 0) begin
              state_d[i] = S_IDLE;
            end else begin
              state_d[i] = S_DELAY;
              dly_d[i]   = DLY_INIT;
            end
          end
          S_DELAY: begin
            if (dly_q[i] <= DLY_W'(1)) begin
              state_d[i] = S_IDLE;
              dly_d[i]   = '0;
            end else begin
              dly_d[i] = dly_q[i] - DLY_W'(1);
            end
          end
          S_IDLE: begin
            if (run_req[i]) begin
              if (NEEDS_OSC[i]) begin
                state_d[i] = S_OREQ;
                to_d[i]    = TO_INIT;
              end else begin
                state_d[i] = S_RUN;
              end
            end
          end
          S_OREQ: begin
            if (osc_rdy) begin
              state_d[i] = S_RUN;
              to_d[i]    = '0;
            end else if (!run_req[i]) begin
              state_d[i] = S_IDLE;
              to_d[i]    = '0;
            end else if (to_q[i] <= TO_W'(1)) begin
              state_d[i] = S_IDLE;
              to_d[i]    = '0;
              err_set[i] = 1'b1;
            end else begin
              to_d[i] = to_q[i] - TO_W'(1);
            end
          end
          S_RUN: begin
            if (!run_req[i]) begin
              state_d[i] = S_IDLE;
            end else if (NEEDS_OSC[i] && !osc_rdy) begin
              state_d[i] = S_OREQ;
              to_d[i]    = TO_INIT;
            end
          end
          default: state_d[i] = S_RESET;
        endcase
      end
      rst_n_d[i] = (state_d[i] != S_RESET);
      en_d[i]    = (state_d[i] == S_RUN);
      req_d[i]   = (state_d[i] == S_OREQ) ||
                   ((state_d[i] == S_RUN) && NEEDS_OSC[i]);
      err_d[i]   = err_set[i] | (err_q[i] & ~err_clr[i]);
    end
    osc_req_d = |req_d;
  end

  always_ff @(posedge i_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < CH_NUM; i++) begin
        state_q[i] <= S_RESET;
        dly_q[i]   <= '0;
        to_q[i]    <= '0;
      end
      rst_n_q   <= '0;
      en_q      <= '0;
      err_q     <= '0;
      osc_req_q <= 1'b0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        state_q[i] <= state_d[i];
        dly_q[i]   <= dly_d[i];
        to_q[i]    <= to_d[i];
      end
      rst_n_q   <= rst_n_d;
      en_q      <= en_d;
      err_q     <= err_d;
      osc_req_q <= osc_req_d;
    end
  end

  assign per_rst_n = rst_n_q;
  assign clk_en    = en_q | {CH_NUM{testmode}};
  assign osc_req   = osc_req_q;
  assign err       = err_q;

endmodule

// File: tb/tb_per_clk_rst_seq.sv
// Scoreboard bench for per_clk_rst_seq: directed scenarios then
// random traffic, checked against a behavioural channel model.
module tb_per_clk_rst_seq;

  localparam int CH = 4;
  localparam int DLY = 2;
  localparam int TO = 8;
  localparam logic [CH-1:0] NEEDS = 4'b1010;

  logic          clk = 1'b0;
  logic          sys_rst;
  logic          testmode;
  logic [CH-1:0] sft_rst_req;
  logic [CH-1:0] run_req;
  logic          osc_rdy;
  logic [CH-1:0] err_clr;
  logic [CH-1:0] per_rst_n;
  logic [CH-1:0] clk_en;
  logic          osc_req;
  logic [CH-1:0] err;

  per_clk_rst_seq #(
    .CH_NUM(CH),
    .CLK_ON_AFTER_PER_RST_RELEASE(DLY),
    .OSC_TIMEOUT(TO),
    .NEEDS_OSC(NEEDS)
  ) dut (
    .i_clk(clk),
    .sys_rst(sys_rst),
    .testmode(testmode),
    .sft_rst_req(sft_rst_req),
    .run_req(run_req),
    .osc_rdy(osc_rdy),
    .err_clr(err_clr),
    .per_rst_n(per_rst_n),
    .clk_en(clk_en),
    .osc_req(osc_req),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0] rst_n;
    logic [CH-1:0] en;
    logic [CH-1:0] err;
    logic          req;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // model: in reset / delay cycles left / waiting on osc (with age) / running
  bit m_rst [CH];
  int m_dly [CH];
  bit m_wait[CH];
  int m_age [CH];
  bit m_run [CH];
  bit m_err [CH];

  task automatic model_step();
    exp_t e;
    bit set;
    e = '0;
    for (int i = 0; i < CH; i++) begin
      set = 1'b0;
      if (sys_rst) begin
        m_rst[i] = 1; m_dly[i] = 0; m_wait[i] = 0;
        m_run[i] = 0; m_age[i] = 0;
      end else if (sft_rst_req[i]) begin
        m_rst[i] = 1; m_dly[i] = 0; m_wait[i] = 0; m_run[i] = 0;
      end else if (m_rst[i]) begin
        m_rst[i] = 0; m_dly[i] = DLY;
      end else if (m_dly[i] > 0) begin
        m_dly[i]--;
      end else if (m_wait[i]) begin
        if (osc_rdy) begin
          m_wait[i] = 0; m_run[i] = 1;
        end else if (!run_req[i]) begin
          m_wait[i] = 0;
        end else if (m_age[i] + 1 == TO) begin
          m_wait[i] = 0; set = 1;
        end else begin
          m_age[i]++;
        end
      end else if (m_run[i]) begin
        if (!run_req[i]) m_run[i] = 0;
        else if (NEEDS[i] && !osc_rdy) begin
          m_run[i] = 0; m_wait[i] = 1; m_age[i] = 0;
        end
      end else if (run_req[i]) begin
        if (NEEDS[i]) begin m_wait[i] = 1; m_age[i] = 0; end
        else m_run[i] = 1;
      end
      m_err[i] = sys_rst ? 1'b0 : (set | (m_err[i] & ~err_clr[i]));
      e.rst_n[i] = !m_rst[i];
      e.en[i]    = m_run[i] | testmode;
      e.err[i]   = m_err[i];
      e.req      = e.req | m_wait[i] | (m_run[i] & NEEDS[i]);
    end
    q.push_back(e);
  endtask

  task automatic drive(input bit rs, input bit tm, input logic [CH-1:0] sft,
                       input logic [CH-1:0] run, input bit rdy,
                       input logic [CH-1:0] clr, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      sys_rst = rs; testmode = tm; sft_rst_req = sft;
      run_req = run; osc_rdy = rdy; err_clr = clr;
      model_step();
    end
  endtask

  function automatic void check(input string name, input logic [CH-1:0] got,
                                input logic [CH-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, got, exp);
    end
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("per_rst_n", per_rst_n, e.rst_n);
        check("clk_en", clk_en, e.en);
        check("err", err, e.err);
        check("osc_req", {3'b0, osc_req}, {3'b0, e.req});
      end
    end
  end

  initial begin
    logic [CH-1:0] run, sft, clr;
    bit rdy, tm, rs;
    sys_rst = 1; testmode = 0; sft_rst_req = '0;
    run_req = '0; osc_rdy = 0; err_clr = '0;
    // reset, with testmode forcing enables while channels held in reset
    drive(1, 0, 4'h0, 4'h0, 0, 4'h0, 2);
    drive(1, 1, 4'h0, 4'h0, 0, 4'h0, 2);
    drive(0, 1, 4'hf, 4'h0, 0, 4'h0, 2);
    // release with ch0 demanding clock: reset rises, enable 3 edges later
    drive(0, 0, 4'h0, 4'h1, 0, 4'h0, 6);
    // ch1 oscillator handshake, ready arrives after 5 cycles
    drive(0, 0, 4'h0, 4'h3, 0, 4'h0, 5);
    drive(0, 0, 4'h0, 4'h3, 1, 4'h0, 4);
    // ready lost in RUN -> OREQ -> timeout with coincident clear
    drive(0, 0, 4'h0, 4'h3, 0, 4'h2, 12);
    drive(0, 0, 4'h0, 4'h0, 0, 4'h0, 2);
    // second timeout, no clear: flag stays sticky, then cleared
    drive(0, 0, 4'h0, 4'h3, 0, 4'h0, 12);
    drive(0, 0, 4'h0, 4'h0, 0, 4'h0, 3);
    drive(0, 0, 4'h0, 4'h0, 0, 4'h2, 1);
    // ch2 soft reset pulse during RUN, full delay repeats
    drive(0, 0, 4'h0, 4'h4, 1, 4'h0, 6);
    drive(0, 0, 4'h4, 4'h4, 1, 4'h0, 1);
    drive(0, 0, 4'h0, 4'h4, 1, 4'h0, 8);
    // random traffic
    run = '0; rdy = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(7) == 0) run[i] = ~run[i];
        sft[i] = ($urandom_range(31) == 0);
        clr[i] = ($urandom_range(7) == 0);
      end
      if ($urandom_range(5) == 0) rdy = ~rdy;
      tm = ($urandom_range(31) == 0);
      rs = ($urandom_range(199) == 0);
      drive(rs, tm, sft, run, rdy, clr, 1);
    end
    drive(0, 0, 4'h0, 4'h0, 0, 4'h0, 2);
    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/per_clk_rst_seq.md
PER_CLK_RST_SEQ -- requirements
Module: per_clk_rst_seq

Interface
REQ-001 Parameter CH_NUM, default 4: number of peripheral channels, legal range 1..16.
REQ-002 Parameter CLK_ON_AFTER_PER_RST_RELEASE, default 2: cycles between channel reset release and first clock-enable eligibility, legal range 0..255.
REQ-003 Parameter OSC_TIMEOUT, default 64: cycles to wait for osc_rdy before declaring failure, legal range 1..1023.
REQ-004 Parameter NEEDS_OSC, CH_NUM bits, default all 0: bit i=1 means channel i kernel clock needs an on-demand oscillator (CSI/HSI class).
REQ-005 i_clk  input  1  single clock for all logic; every output register updates on its rising edge.
REQ-006 sys_rst  input  1  synchronous, active-high reset.
REQ-007 testmode  input  1  when high, forces every clk_en bit to 1 combinationally; FSMs are unaffected.
REQ-008 sft_rst_req  input  CH_NUM  per-channel software reset request, level-sensitive.
REQ-009 run_req  input  CH_NUM  per-channel clock demand (bus/LP/AM enable already combined upstream).
REQ-010 osc_rdy  input  1  shared oscillator ready.
REQ-011 err_clr  input  CH_NUM  per-channel single-cycle clear of err.
REQ-012 per_rst_n  output  CH_NUM  registered per-channel peripheral reset, active-low.
REQ-013 clk_en  output  CH_NUM  registered per-channel enable into the external clock-gating cells.
REQ-014 osc_req  output  1  registered OR of all channel oscillator requests.
REQ-015 err  output  CH_NUM  sticky per-channel oscillator timeout flag.

Function
REQ-016 Each channel shall run an independent FSM with states RESET, DELAY, IDLE, OREQ, RUN.
REQ-017 RESET: per_rst_n=0, clk_en=0; when sft_rst_req[i]=0, load the delay counter with CLK_ON_AFTER_PER_RST_RELEASE and go to DELAY, or go to IDLE if the parameter is 0.
REQ-018 DELAY: per_rst_n=1, clk_en=0; decrement the counter each cycle; at count 1 go to IDLE, so per_rst_n is high for exactly CLK_ON_AFTER_PER_RST_RELEASE cycles before IDLE.
REQ-019 IDLE: per_rst_n=1, clk_en=0; on run_req[i]=1 go to OREQ if NEEDS_OSC[i]=1, otherwise go to RUN.
REQ-020 OREQ: channel oscillator request=1, clk_en=0; load the timeout counter with OSC_TIMEOUT on entry; on osc_rdy=1 go to RUN; if OSC_TIMEOUT cycles elapse without osc_rdy, set err[i] and go to IDLE.
REQ-021 OREQ with run_req[i]=0 and osc_rdy=0 shall go to IDLE with no err.
REQ-022 RUN: clk_en=1, channel oscillator request=NEEDS_OSC[i]; on run_req[i]=0 go to IDLE, so clk_en drops on the next edge.
REQ-023 RUN with NEEDS_OSC[i]=1 and osc_rdy=0 shall go to OREQ, deasserting clk_en, with the timeout counter reloaded.
REQ-024 sft_rst_req[i]=1 in any state shall move the channel to RESET on the next edge; this takes priority over every other transition, including the OREQ timeout.
REQ-025 osc_req shall be registered from the next-state channel requests, so it is high in the same cycle the first channel enters OREQ.
REQ-026 Setting err[i] and err_clr[i] in the same cycle shall leave err[i]=1 (set wins); otherwise err_clr[i] clears the bit.
REQ-027 clk_en[i] = fsm_clk_en[i] OR testmode, with no register after the OR.
REQ-028 Counter widths shall be ceil(log2(max+1)) of the respective parameter; counters shall never wrap.

Reset
REQ-029 sys_rst=1 shall put all channels in RESET with per_rst_n=0, clk_en=0 (testmode aside), osc_req=0, err=0, and counters at 0.
REQ-030 After sys_rst falls, each channel shall leave RESET per REQ-017 on the first edge where its sft_rst_req bit is 0.
REQ-031 sys_rst asserted mid-sequence, in any state, shall override all inputs on that edge.

Verification
REQ-032 Release at cycle 0 with sys_rst and sft_rst_req=0, default parameters, run_req[0]=1, NEEDS_OSC=0 -> per_rst_n[0] rises at cycle 1, clk_en[0] rises at cycle 4.
REQ-033 NEEDS_OSC[1]=1, run_req[1]=1, osc_rdy rising 5 cycles after osc_req -> clk_en[1] rises on the edge after osc_rdy, err[1]=0.
REQ-034 OSC_TIMEOUT=8, osc_rdy held 0 -> err[1] set 8 cycles after OREQ entry, channel in IDLE, osc_req=0 on the following cycle.
REQ-035 sft_rst_req[2] pulsed during RUN -> clk_en[2]=0 and per_rst_n[2]=0 on the next edge; the full DELAY sequence repeats after release.
REQ-036 testmode=1 during RESET -> clk_en all 1, per_rst_n still 0; err_clr and timeout coincident -> err remains 1.
